mem_arbiter: RTL

//  Shares the single-port 32x8 data/program memory between the CPU core and an

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data/program memory between the CPU and the loader/debug port.
// Define ARB_ROUND_ROBIN_EN to break IDLE ties against the last owner; otherwise LDR wins ties.
module mem_arbiter #(
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ldr_req,
  input  logic              ldr_wr,
  input  logic [AWIDTH-1:0] ldr_addr,
  input  logic [DWIDTH-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_stall,
  output logic [DWIDTH-1:0] ldr_rdata,
  output logic              ldr_rvalid,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_OWN_CPU, S_OWN_LDR} state_t;

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);

  state_t              r_state;
  state_t              w_next;
  logic [HW-1:0]       r_hold;
  logic                r_cpu_rvalid;
  logic                r_ldr_rvalid;
  logic [DWIDTH-1:0]   r_cpu_rdata;
  logic [DWIDTH-1:0]   r_ldr_rdata;
  logic                w_cpu_acc;
  logic                w_ldr_acc;
  logic                w_contested;
  logic                w_tie_ldr;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_ldr;
  assign w_tie_ldr = ~r_last_ldr;
`else
  assign w_tie_ldr = 1'b1;
`endif

  assign cpu_gnt   = (r_state == S_OWN_CPU);
  assign ldr_gnt   = (r_state == S_OWN_LDR);
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign ldr_stall = ldr_req & ~ldr_gnt;

  // Gating with rst keeps the memory untouched while reset is asserted.
  assign w_cpu_acc = rst & cpu_req & cpu_gnt;
  assign w_ldr_acc = rst & ldr_req & ldr_gnt;

  assign mem_rd       = (w_cpu_acc & ~cpu_wr) | (w_ldr_acc & ~ldr_wr);
  assign mem_wr       = (w_cpu_acc &  cpu_wr) | (w_ldr_acc &  ldr_wr);
  assign mem_wdata_oe = mem_wr;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_acc) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_ldr_acc) begin
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  assign w_contested = ((r_state == S_OWN_CPU) & ldr_req) |
                       ((r_state == S_OWN_LDR) & cpu_req);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_req && ldr_req) w_next = w_tie_ldr ? S_OWN_LDR : S_OWN_CPU;
        else if (ldr_req)       w_next = S_OWN_LDR;
        else if (cpu_req)       w_next = S_OWN_CPU;
      end
      S_OWN_CPU: begin
        if (!cpu_req)                           w_next = ldr_req ? S_OWN_LDR : S_IDLE;
        else if (ldr_req && r_hold == HOLD_LAST) w_next = S_OWN_LDR;
      end
      S_OWN_LDR: begin
        if (!ldr_req)                           w_next = cpu_req ? S_OWN_CPU : S_IDLE;
        else if (cpu_req && r_hold == HOLD_LAST) w_next = S_OWN_CPU;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || !w_contested) r_hold <= '0;
      else if (r_hold != HOLD_MAX)           r_hold <= r_hold + 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_ldr <= 1'b1;
    end else if (w_next != r_state) begin
      if (w_next == S_OWN_LDR)      r_last_ldr <= 1'b1;
      else if (w_next == S_OWN_CPU) r_last_ldr <= 1'b0;
    end
  end
`endif

  // Read data is captured at the access edge and held until the next read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ldr_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= w_cpu_acc & ~cpu_wr;
      r_ldr_rvalid <= w_ldr_acc & ~ldr_wr;
      if (w_cpu_acc && !cpu_wr) r_cpu_rdata <= mem_rdata;
      if (w_ldr_acc && !ldr_wr) r_ldr_rdata <= mem_rdata;
    end
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign ldr_rvalid = r_ldr_rvalid;
  assign cpu_rdata  = r_cpu_rdata;
  assign ldr_rdata  = r_ldr_rdata;

endmodule
